// File: rtl/bomb_pkg.sv
// bomb_pkg: shared state encoding, digit width and preset validation for the bomb countdown
package bomb_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_PAUSED   = 3'd2,
    ST_DEFUSED  = 3'd3,
    ST_EXPLODED = 3'd4
  } state_t;
  function automatic logic preset_valid(input logic [4*BCD_W-1:0] p);
    return p[15:12] <= 4'd9 && p[11:8] <= 4'd9 && p[7:4] <= 4'd5 && p[3:0] <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_mmss_down.sv
// bcd_mmss_down: mm:ss BCD register with parallel load and one-second borrow-chain decrement
module bcd_mmss_down import bomb_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [4*BCD_W-1:0] preset,
  output logic [4*BCD_W-1:0] digits,
  output logic               is_zero,
  output logic               next_zero
);
  logic [BCD_W-1:0] so, st, mo, mt;
  logic b0, b1, b2;
  logic [4*BCD_W-1:0] dec_val;
  // borrow ripples sec_o -> sec_t (wraps to 5) -> min_o -> min_t
  always_comb begin
    {mt, mo, st, so} = digits;
    b0 = so == '0;
    b1 = b0 && st == '0;
    b2 = b1 && mo == '0;
    dec_val = {b2 ? mt - 1'b1 : mt,
               b1 ? (mo == '0 ? BCD_W'(9) : mo - 1'b1) : mo,
               b0 ? (st == '0 ? BCD_W'(5) : st - 1'b1) : st,
               b0 ? BCD_W'(9) : so - 1'b1};
  end
  assign is_zero   = digits == '0;
  assign next_zero = digits == (4*BCD_W)'(1);
  // digit register: reset, then load, then decrement
  always_ff @(posedge clk)
    digits <= !rst ? '0 : load ? preset : dec ? dec_val : digits;
endmodule

// File: rtl/bomb_countdown_ctrl.sv
// bomb_countdown_ctrl: arm/pause/strike/defuse/explode sequencer with ms sub-counter and BCD countdown
module bomb_countdown_ctrl import bomb_pkg::*; #(
  parameter int MS_PER_SEC  = 1000,
  parameter int MAX_STRIKES = 3,
  parameter int MS_CNT_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_tick,
  output logic        tick_en,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        pause,
  input  logic        strike,
  input  logic        defuse_ok,
  output logic [15:0] digits,
  output logic [2:0]  state,
  output logic [1:0]  strikes,
  output logic        sec_pulse,
  output logic        exploded,
  output logic        defused,
  output logic        load_err
);
  state_t st;
  logic [MS_CNT_W-1:0] ms_cnt, lim;
  logic [1:0] strikes_nx;
  logic idle, armed, paused, active, strike_ev, strike_boom, at_lim, dec_go, zero_boom;
  logic load_go, load_bad, is_zero, next_zero;
  // event decode in priority order: strike, zero-reach, defuse, pause, start
  always_comb begin
    idle        = st == ST_IDLE;
    armed       = st == ST_ARMED;
    paused      = st == ST_PAUSED;
    active      = armed || paused;
    strike_ev   = active && strike;
    strikes_nx  = strikes + 2'd1;
    strike_boom = strike_ev && strikes_nx == 2'(MAX_STRIKES);
    lim         = MS_CNT_W'((MS_PER_SEC >> strikes) - 1);
    at_lim      = ms_cnt == lim;
    dec_go      = armed && ms_tick && !strike_ev && at_lim && (next_zero || !(pause || defuse_ok));
    zero_boom   = dec_go && next_zero;
    load_go     = idle && load && preset_valid(preset);
    load_bad    = idle && load && !preset_valid(preset);
  end
  assign tick_en = armed;
  assign state   = st;
  bcd_mmss_down u_digits (
    .clk       (clk),
    .rst       (rst),
    .load      (load_go),
    .dec       (dec_go),
    .preset    (preset),
    .digits    (digits),
    .is_zero   (is_zero),
    .next_zero (next_zero)
  );
  // game FSM, strike counter, ms sub-counter and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= ST_IDLE;
      strikes   <= '0;
      ms_cnt    <= '0;
      sec_pulse <= 1'b0;
      exploded  <= 1'b0;
      defused   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= dec_go;
      load_err  <= load_bad;
      if (strike_ev) strikes <= strikes_nx;
      if (strike_ev) ms_cnt <= '0;
      else if (armed && ms_tick && !pause) ms_cnt <= at_lim ? '0 : ms_cnt + 1'b1;
      if (strike_boom || zero_boom) begin
        st       <= ST_EXPLODED;
        exploded <= 1'b1;
      end else if (active && defuse_ok) begin
        st      <= ST_DEFUSED;
        defused <= 1'b1;
      end else if (armed && pause) st <= ST_PAUSED;
      else if ((paused && start) || (idle && start && !is_zero)) st <= ST_ARMED;
    end
  end
endmodule
